mul32_booth_seq: RTL and testbench

Sequential 32×32 signed multiplier for the mini processor's ALU. It computes a full 64-bit two's-complement product using radix-2 Booth recoding: one add, subtract or pass step plus an arithmetic shift per clock. Its 64-bit `result` drives a data input of the ALU's 64-bit 8:1 result multiplexer. The add/subtract path is a 33-bit adder built from the existing 32-bit CLA plus a sign-extension bit.

---
 rtl/mul32_booth_seq.sv | 198 +++++++++++++++++++
 tb/tb_mul32_booth_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mul32_booth_seq.sv
//------------------------------------------------------------------------------
// Module      : mul32_booth_seq
// Description : Sequential 32x32 signed radix-2 Booth multiplier, 64-bit product.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mul32_booth_cla32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);
    localparam int c_groups = 8;

    logic [c_groups:0] w_gc;

    assign w_gc[0] = i_cin;

    genvar gi;
    generate
        for (gi = 0; gi < c_groups; gi++) begin : g_grp
            logic [3:0] w_g;
            logic [3:0] w_p;
            logic [3:0] w_c;
            logic       w_grp_g;
            logic       w_grp_p;

            assign w_g = i_a[4*gi +: 4] & i_b[4*gi +: 4];
            assign w_p = i_a[4*gi +: 4] ^ i_b[4*gi +: 4];

            // In-group carries look ahead from the group carry-in.
            assign w_c[0] = w_gc[gi];
            assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
            assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
            assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                          | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);

            assign w_grp_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                           | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
            assign w_grp_p = &w_p;

            assign w_gc[gi+1]     = w_grp_g | (w_grp_p & w_gc[gi]);
            assign o_sum[4*gi +: 4] = w_p ^ w_c;
        end
    endgenerate

    assign o_cout = w_gc[c_groups];
endmodule

module mul32_booth_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_start,
    input  logic        op_clear,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic [63:0] result,
    output logic        op_done
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0] c_last_step = 6'd31;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [32:0] r_u;
    logic [31:0] r_q;
    logic        r_qm1;
    logic [32:0] r_m;
    logic [5:0]  r_cnt;
    logic [63:0] r_result;

    logic        w_load;
    logic        w_step;
    logic        w_finish;

    logic [1:0]  w_pair;
    logic [32:0] w_addend;
    logic        w_cin;
    logic [31:0] w_sum_lo;
    logic        w_carry;
    logic [32:0] w_t;
    logic [32:0] w_u_nxt;
    logic [31:0] w_q_nxt;

    // Booth recoding: 01 adds M, 10 subtracts M (invert plus carry-in), else pass.
    assign w_pair = {r_q[0], r_qm1};

    always_comb begin
        w_addend = 33'd0;
        w_cin    = 1'b0;
        case (w_pair)
            2'b01:   w_addend = r_m;
            2'b10: begin
                w_addend = ~r_m;
                w_cin    = 1'b1;
            end
            default: w_addend = 33'd0;
        endcase
    end

    mul32_booth_cla32 u_cla (
        .i_a    (r_u[31:0]),
        .i_b    (w_addend[31:0]),
        .i_cin  (w_cin),
        .o_sum  (w_sum_lo),
        .o_cout (w_carry)
    );

    // Sign-extension bit completes the 33-bit sum above the 32-bit CLA.
    assign w_t     = {r_u[32] ^ w_addend[32] ^ w_carry, w_sum_lo};
    assign w_u_nxt = {w_t[32], w_t[32:1]};
    assign w_q_nxt = {w_t[0], r_q[31:1]};

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (op_start) begin
                    w_state_nxt = S_EXEC;
                    w_load      = 1'b1;
                end
            end
            S_EXEC: begin
                w_step = 1'b1;
                if (r_cnt == c_last_step) begin
                    w_state_nxt = S_DONE;
                    w_finish    = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (op_clear) begin
            w_state_nxt = S_IDLE;
            w_load      = 1'b0;
            w_step      = 1'b0;
            w_finish    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_u      <= 33'd0;
            r_q      <= 32'd0;
            r_qm1    <= 1'b0;
            r_m      <= 33'd0;
            r_cnt    <= 6'd0;
            r_result <= 64'd0;
        end else if (op_clear) begin
            r_u      <= 33'd0;
            r_q      <= 32'd0;
            r_qm1    <= 1'b0;
            r_cnt    <= 6'd0;
            r_result <= 64'd0;
        end else begin
            if (w_load) begin
                r_u   <= 33'd0;
                r_q   <= multiplier;
                r_qm1 <= 1'b0;
                r_m   <= {multiplicand[31], multiplicand};
                r_cnt <= 6'd0;
            end else if (w_step) begin
                r_u   <= w_u_nxt;
                r_q   <= w_q_nxt;
                r_qm1 <= r_q[0];
                r_cnt <= r_cnt + 6'd1;
            end
            // Product is published only on the final step, never partially.
            if (w_finish) begin
                r_result <= {w_u_nxt[31:0], w_q_nxt};
            end
        end
    end

    assign result  = r_result;
    assign op_done = (r_state == S_DONE);
endmodule

`default_nettype wire

// File: tb/tb_mul32_booth_seq.sv
//------------------------------------------------------------------------------
// Module      : tb_mul32_booth_seq
// Description : Self-checking bench for mul32_booth_seq against a signed-multiply model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mul32_booth_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_start = 1'b0;
    logic        op_clear = 1'b0;
    logic [31:0] multiplicand = 32'd0;
    logic [31:0] multiplier = 32'd0;
    logic [63:0] result;
    logic        op_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int t_start  = 0;

    mul32_booth_seq dut (
        .clk          (clk),
        .reset        (reset),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .result       (result),
        .op_done      (op_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
        longint a;
        longint b;
        a = longint'($signed(m));
        b = longint'($signed(q));
        return a * b;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] m, input logic [31:0] q);
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        op_start     = 1'b1;
        @(posedge clk);
        #1;
        op_start     = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    task automatic start_op(input logic [31:0] m, input logic [31:0] q);
        pulse_start(m, q);
        t_start = cycle;
    endtask

    task automatic wait_done(input string tag, input logic [63:0] exp);
        bit partial = 0;
        int budget  = 40;
        while (!op_done && budget > 0) begin
            tick(1);
            budget--;
            if (!op_done && result != 64'd0) partial = 1;
        end
        check({tag, "_latency"}, 64'(cycle - t_start), 64'd32);
        check({tag, "_no_partial"}, 64'(partial), 64'd0);
        check({tag, "_product"}, result, exp);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        op_clear = 1'b1;
        @(posedge clk);
        #1;
        op_clear = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic do_mul(input string tag, input logic [31:0] m, input logic [31:0] q);
        start_op(m, q);
        wait_done(tag, ref_mul(m, q));
        pulse_clear();
        check({tag, "_clr"}, {result, 63'd0, op_done}, 128'd0);
    endtask

    initial begin
        logic [63:0] saved;
        logic [31:0] corner [6];
        corner[0] = 32'h8000_0000; corner[1] = 32'h7FFF_FFFF; corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'd0;         corner[4] = 32'd1;         corner[5] = 32'h8000_0001;

        tick(3);
        reset = 1'b0;
        check("reset_result", result, 64'd0);
        check("reset_done", 64'(op_done), 64'd0);

        // Basic case, then hold for 10 idle cycles.
        start_op(32'd7, 32'd3);
        wait_done("basic", 64'h0000_0000_0000_0015);
        tick(10);
        check("basic_hold", result, 64'h15);
        check("basic_hold_done", 64'(op_done), 64'd1);
        pulse_clear();

        do_mul("mixed_a", 32'hFFFF_FFFB, 32'd6);
        do_mul("mixed_b", 32'd6, 32'hFFFF_FFFB);
        do_mul("min_min", 32'h8000_0000, 32'h8000_0000);
        do_mul("neg1_neg1", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_mul("max_min", 32'h7FFF_FFFF, 32'h8000_0000);
        check("model_max_min", ref_mul(32'h7FFF_FFFF, 32'h8000_0000), 64'hC000_0000_8000_0000);

        // Abort mid-EXEC, then a fresh start must see full latency.
        start_op(32'd123, 32'd456);
        tick(9);
        pulse_clear();
        check("abort_result", result, 64'd0);
        check("abort_done", 64'(op_done), 64'd0);
        tick(40);
        check("abort_stays_idle", 64'(op_done), 64'd0);
        do_mul("after_abort", 32'd2, 32'hFFFF_FFFD);

        // Start re-pulses during EXEC and DONE are ignored.
        start_op(32'd1000, 32'hFFFF_FF00);
        tick(5);
        pulse_start(32'd3, 32'd3);
        wait_done("ign_exec", ref_mul(32'd1000, 32'hFFFF_FF00));
        saved = result;
        pulse_start(32'd9, 32'd9);
        tick(3);
        check("ign_done_result", result, saved);
        check("ign_done_flag", 64'(op_done), 64'd1);
        pulse_clear();

        // Reset mid-EXEC and in DONE.
        start_op(32'd77, 32'd88);
        tick(10);
        pulse_reset();
        check("rst_exec", {result, 63'd0, op_done}, 128'd0);
        tick(40);
        check("rst_exec_idle", 64'(op_done), 64'd0);
        start_op(32'd77, 32'd88);
        wait_done("pre_rst", 64'd6776);
        pulse_reset();
        check("rst_done", {result, 63'd0, op_done}, 128'd0);

        // Start and clear together in IDLE: nothing starts.
        @(negedge clk);
        op_start = 1'b1;
        op_clear = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        op_clear = 1'b0;
        tick(40);
        check("start_clear_idle", {result, 63'd0, op_done}, 128'd0);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] m;
            logic [31:0] q;
            m = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            q = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            do_mul($sformatf("rand%0d", i), m, q);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
